// File: rtl/blink_pkg.sv
// Shared types and constants for the blink rate controller.
// Debounce state encoding, rate index width and reset rate.
package blink_pkg;

    localparam int RATE_IDX_W = 2;
    localparam logic [RATE_IDX_W-1:0] RESET_RATE_IDX = 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    // Last count value of the half-period for rate index k.
    function automatic int unsigned half_period_last(
        input int unsigned half,
        input logic [RATE_IDX_W-1:0] k
    );
        return (half >> k) - 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer and debounce FSM.
// press_qual marks the edge that enters PRESSED; press_pulse is its registered copy.
module btn_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 960_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press_pulse,
    output logic press_qual
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q;
    logic          btn_s;
    db_state_t     state;
    db_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          qual;

    // Synchronizer resets to the released level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b1;
            btn_s  <= 1'b1;
        end else begin
            sync_q <= btn_n;
            btn_s  <= sync_q;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        qual      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    qual      = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_pulse <= qual;
        end
    end

    assign press_qual = qual;

endmodule

// File: rtl/blink_rate_ctrl.sv
// Button-selected blink rate with a tick strobe at the chosen half-period.
// Rate index steps 0..3 per qualified press; each step halves the half-period.
module blink_rate_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 48_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 960_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  btn_n,
    input  logic                  enable,
    output logic                  tick,
    output logic [RATE_IDX_W-1:0] rate_idx,
    output logic                  press_pulse
);

    localparam int unsigned HALF = CLK_FREQ_HZ / 2;
    localparam int unsigned TW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_last;
    logic          press_qual;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (btn_n),
        .press_pulse(press_pulse),
        .press_qual (press_qual)
    );

    assign cnt_last = TW'(half_period_last(HALF, rate_idx));

    // A rate change restarts the period and suppresses that cycle's tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            tick     <= 1'b0;
            rate_idx <= RESET_RATE_IDX;
        end else if (press_qual) begin
            rate_idx <= rate_idx + 1'b1;
            cnt      <= '0;
            tick     <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == cnt_last) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Self-checking bench for blink_rate_ctrl (CLK_FREQ_HZ=16, DEBOUNCE_CYCLES=4).
// Press pulses are checked against a queue of expected (cycle, rate) entries.
module tb_blink_rate_ctrl;

    logic       clk;
    logic       reset_n;
    logic       btn_n;
    logic       enable;
    logic       tick;
    logic [1:0] rate_idx;
    logic       press_pulse;

    typedef struct {
        int         cyc;
        logic [1:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [1:0] exp_rate = 2'd1;

    blink_rate_ctrl #(
        .CLK_FREQ_HZ    (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (btn_n),
        .enable     (enable),
        .tick       (tick),
        .rate_idx   (rate_idx),
        .press_pulse(press_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every observed press pulse must match the queue head.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && press_pulse !== 1'b0) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_pulse: cyc=%0d rate=%0d", cyc, rate_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc !== e.cyc || rate_idx !== e.idx) begin
                    bad = bad + 1;
                    $display("FAIL press: got cyc=%0d rate=%0d want cyc=%0d rate=%0d",
                             cyc, rate_idx, e.cyc, e.idx);
                end
            end
        end
    end

    task automatic push_press(input int at_cyc);
        exp_t e;
        exp_rate = exp_rate + 2'd1;
        e.cyc = at_cyc;
        e.idx = exp_rate;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_n   = 1'b1;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        total = total + 3;
        if (rate_idx !== 2'd1) begin
            bad = bad + 1;
            $display("FAIL reset_rate: got %0d want 1", rate_idx);
        end
        if (tick !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_tick: got %b want 0", tick);
        end
        if (press_pulse !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_pulse: got %b want 0", press_pulse);
        end
        reset_n = 1'b1;
        exp_rate = 2'd1;
        repeat (2) @(negedge clk);
        total = total + 1;
        if (tick !== 1'b0 || rate_idx !== 2'd1) begin
            bad = bad + 1;
            $display("FAIL post_reset: got tick=%b rate=%0d want tick=0 rate=1", tick, rate_idx);
        end
    endtask

    task automatic test_idle_tick();
        enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            total = total + 1;
            if (tick !== ((i % 4) == 0)) begin
                bad = bad + 1;
                $display("FAIL idle_tick: step=%0d got %b want %b", i, tick, (i % 4) == 0);
            end
        end
    endtask

    task automatic test_clean_press();
        int k;
        k = cyc;
        btn_n = 1'b0;
        push_press(k + 7);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i >= 7 && i <= 19) begin
                total = total + 1;
                if (tick !== (i > 7 && ((i - 7) % 2) == 0)) begin
                    bad = bad + 1;
                    $display("FAIL rate2_tick: step=%0d got %b", i, tick);
                end
            end
            if (i == 20) btn_n = 1'b1;
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL clean_missing: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int   k;
        logic pat[0:40];
        for (int i = 0; i <= 40; i++) pat[i] = 1'b1;
        for (int i = 0; i <= 2; i++) pat[i] = 1'b0;
        for (int i = 4; i <= 13; i++) pat[i] = 1'b0;
        pat[15] = 1'b0;
        k = cyc;
        push_press(k + 11);
        for (int i = 0; i <= 40; i++) begin
            if (i == 11) begin
                total = total + 1;
                if (tick !== 1'b0) begin
                    bad = bad + 1;
                    $display("FAIL bounce_change_tick: got %b want 0", tick);
                end
            end
            if (i >= 12 && i <= 20) begin
                total = total + 1;
                if (tick !== 1'b1) begin
                    bad = bad + 1;
                    $display("FAIL rate3_tick: step=%0d got %b want 1", i, tick);
                end
            end
            btn_n = pat[i];
            @(negedge clk);
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL bounce_missing: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_four_presses();
        int k;
        for (int p = 0; p < 4; p++) begin
            k = cyc;
            btn_n = 1'b0;
            push_press(k + 7);
            for (int i = 1; i <= 24; i++) begin
                @(negedge clk);
                if (i == 7) begin
                    total = total + 1;
                    if (tick !== 1'b0) begin
                        bad = bad + 1;
                        $display("FAIL change_tick: press=%0d got %b want 0", p, tick);
                    end
                end
                if (p == 3 && i > 7 && i <= 16) begin
                    total = total + 1;
                    if (tick !== 1'b1) begin
                        bad = bad + 1;
                        $display("FAIL p1_tick: step=%0d got %b want 1", i, tick);
                    end
                end
                if (i == 12) btn_n = 1'b1;
            end
        end
        total = total + 1;
        if (exp_q.size() != 0 || rate_idx !== 2'd3) begin
            bad = bad + 1;
            $display("FAIL wrap_seq: got pending=%0d rate=%0d want 0 and 3",
                     exp_q.size(), rate_idx);
        end
    endtask

    task automatic test_enable_gap();
        int k;
        k = cyc;
        btn_n = 1'b0;
        push_press(k + 7);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        btn_n  = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            total = total + 1;
            if (tick !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL gap_tick: step=%0d got %b want 0", j, tick);
            end
        end
        enable = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            total = total + 1;
            if (tick !== (j == 8)) begin
                bad = bad + 1;
                $display("FAIL resume_tick: step=%0d got %b want %b", j, tick, j == 8);
            end
        end
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL gap_missing: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        btn_n = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total = total + 1;
            if (press_pulse !== 1'b0 || rate_idx !== 2'd1) begin
                bad = bad + 1;
                $display("FAIL mid_reset: got pulse=%b rate=%0d want 0 and 1",
                         press_pulse, rate_idx);
            end
        end
        reset_n  = 1'b1;
        exp_rate = 2'd1;
        push_press(cyc + 7);
        repeat (12) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        total = total + 1;
        if (exp_q.size() != 0 || rate_idx !== 2'd2) begin
            bad = bad + 1;
            $display("FAIL requalify: got pending=%0d rate=%0d want 0 and 2",
                     exp_q.size(), rate_idx);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_n   = 1'b1;
        enable  = 1'b0;
        test_reset();
        test_idle_tick();
        test_clean_press();
        test_bounce();
        test_four_presses();
        test_enable_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
